// File: rtl/ysyx_23060025_axi_arbiter_if.sv
// AXI4-Lite bus bundle shared by the IFU, LSU and memory sides of the arbiter.
// Every channel is valid/ready: a beat transfers on the edge where both are high.
interface ysyx_23060025_axi_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060025_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// Grants one whole transaction at a time; writes win, reads alternate round-robin.
module ysyx_23060025_axi_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  ysyx_23060025_axi_arbiter_if.slave  ifu,
  ysyx_23060025_axi_arbiter_if.slave  lsu,
  ysyx_23060025_axi_arbiter_if.master m,
  output logic [1:0]                state_dbg,
  output logic                      last_rd_dbg
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  state_t state, next_state, grant;
  logic   last_rd;
  logic   ifu_req, lsu_rreq, lsu_wreq;

  assign ifu_req  = ifu.arvalid;
  assign lsu_rreq = lsu.arvalid;
  assign lsu_wreq = lsu.awvalid | lsu.wvalid;

  // Reset masks the grant immediately so no handshake leaks out during reset.
  assign grant = reset ? IDLE : state;

  assign state_dbg   = state;
  assign last_rd_dbg = last_rd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      last_rd <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state == IFU_RD) last_rd <= 1'b0;
      else if (state == IDLE && next_state == LSU_RD) last_rd <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (lsu_wreq)                  next_state = LSU_WR;
        else if (ifu_req && lsu_rreq)  next_state = last_rd ? IFU_RD : LSU_RD;
        else if (ifu_req)              next_state = IFU_RD;
        else if (lsu_rreq)             next_state = LSU_RD;
      end
      IFU_RD, LSU_RD: if (m.rvalid && m.rready) next_state = IDLE;
      LSU_WR:         if (m.bvalid && m.bready) next_state = IDLE;
      default:        next_state = IDLE;
    endcase
  end

  always_comb begin
    m.araddr  = {ADDR_WIDTH{1'b0}};
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awaddr  = {ADDR_WIDTH{1'b0}};
    m.awvalid = 1'b0;
    m.wdata   = {DATA_WIDTH{1'b0}};
    m.wstrb   = {STRB_WIDTH{1'b0}};
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;

    // Read data/response are broadcast; only the granted rvalid qualifies them.
    ifu.rdata   = m.rdata;
    ifu.rresp   = m.rresp;
    ifu.arready = 1'b0;
    ifu.rvalid  = 1'b0;
    ifu.awready = 1'b0;
    ifu.wready  = 1'b0;
    ifu.bresp   = 2'b00;
    ifu.bvalid  = 1'b0;

    lsu.rdata   = m.rdata;
    lsu.rresp   = m.rresp;
    lsu.bresp   = m.bresp;
    lsu.arready = 1'b0;
    lsu.rvalid  = 1'b0;
    lsu.awready = 1'b0;
    lsu.wready  = 1'b0;
    lsu.bvalid  = 1'b0;

    case (grant)
      IFU_RD: begin
        m.araddr    = ifu.araddr;
        m.arvalid   = ifu.arvalid;
        ifu.arready = m.arready;
        ifu.rvalid  = m.rvalid;
        m.rready    = ifu.rready;
      end
      LSU_RD: begin
        m.araddr    = lsu.araddr;
        m.arvalid   = lsu.arvalid;
        lsu.arready = m.arready;
        lsu.rvalid  = m.rvalid;
        m.rready    = lsu.rready;
      end
      LSU_WR: begin
        m.awaddr    = lsu.awaddr;
        m.awvalid   = lsu.awvalid;
        lsu.awready = m.awready;
        m.wdata     = lsu.wdata;
        m.wstrb     = lsu.wstrb;
        m.wvalid    = lsu.wvalid;
        lsu.wready  = m.wready;
        lsu.bvalid  = m.bvalid;
        m.bready    = lsu.bready;
      end
      default: ;
    endcase
  end
endmodule
